// File: rtl/vfd_pkg.sv
// Shared constants for the VFD/LED demo blocks: pattern mode codes and the
// sequencer state encoding.
package vfd_pkg;

    localparam logic [1:0] MODE_ROL    = 2'd0;
    localparam logic [1:0] MODE_ROR    = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_COUNT  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/vfd_edge_detect.sv
// Rising-edge detector for a level already in the clk domain.
// The flop's reset value is a parameter so a level that is high out of reset can be kept from firing.
module vfd_edge_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    logic level_q;
    logic level_d;

    always_comb level_d = i_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) level_q <= RST_VAL;
        else     level_q <= level_d;
    end

    assign o_rise = i_level & ~level_q;

endmodule

// File: rtl/vfd_led_sequencer.sv
// Advances an LED pattern on each rising edge of the prescaler tick.
// There are four pattern modes and a run/pause control.
//
// state   | meaning
// S_IDLE  | after reset, LEDs dark, waiting for i_run to load the first seed
// S_RUN   | pattern advances (or reseeds on a mode change) on each tick edge
// S_PAUSE | pattern held, edges ignored until i_run returns
module vfd_led_sequencer
    import vfd_pkg::*;
#(
    parameter int N_LEDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_tick,
    input  logic              i_run,
    input  logic [1:0]        i_mode,
    output logic [N_LEDS-1:0] o_led,
    output logic              o_step
);

    localparam logic [N_LEDS-1:0] SEED_LSB = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] SEED_MSB = {1'b1, {(N_LEDS-1){1'b0}}};

    state_t            state_q, state_d;
    logic [N_LEDS-1:0] led_q, led_d;
    logic [1:0]        mode_q, mode_d;
    logic              dir_up_q, dir_up_d;
    logic              step_q, step_d;

    logic              tick_edge;
    logic [N_LEDS-1:0] seed_led;
    logic [N_LEDS-1:0] adv_led;
    logic              adv_dir_up;

    vfd_edge_detect #(.RST_VAL(1'b1)) u_tick_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level (i_tick),
        .o_rise  (tick_edge)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_run)  state_d = S_RUN;
            S_RUN:   if (!i_run) state_d = S_PAUSE;
            S_PAUSE: if (i_run)  state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Seed selection follows the live i_mode: it is used on entry from idle and on a mode change.
    always_comb begin
        seed_led = SEED_LSB;
        case (i_mode)
            MODE_ROL:    seed_led = SEED_LSB;
            MODE_ROR:    seed_led = SEED_MSB;
            MODE_BOUNCE: seed_led = SEED_LSB;
            MODE_COUNT:  seed_led = '0;
            default:     seed_led = SEED_LSB;
        endcase
    end

    // Bounce flips direction on the step that lands on an end bit, so each end shows exactly once.
    always_comb begin
        adv_led    = led_q;
        adv_dir_up = dir_up_q;
        case (mode_q)
            MODE_ROL: adv_led = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
            MODE_ROR: adv_led = {led_q[0], led_q[N_LEDS-1:1]};
            MODE_BOUNCE: begin
                if (dir_up_q) begin
                    adv_led = led_q << 1;
                    if (adv_led[N_LEDS-1]) adv_dir_up = 1'b0;
                end else begin
                    adv_led = led_q >> 1;
                    if (adv_led[0]) adv_dir_up = 1'b1;
                end
            end
            MODE_COUNT: adv_led = led_q + N_LEDS'(1);
            default:    adv_led = led_q;
        endcase
    end

    always_comb begin
        led_d    = led_q;
        mode_d   = mode_q;
        dir_up_d = dir_up_q;
        step_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_run) begin
                    led_d    = seed_led;
                    mode_d   = i_mode;
                    dir_up_d = 1'b1;
                    step_d   = 1'b1;
                end
            end
            S_RUN: begin
                if (i_run && tick_edge) begin
                    mode_d = i_mode;
                    step_d = 1'b1;
                    if (i_mode != mode_q) begin
                        led_d    = seed_led;
                        dir_up_d = 1'b1;
                    end else begin
                        led_d    = adv_led;
                        dir_up_d = adv_dir_up;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q    <= '0;
            mode_q   <= MODE_ROL;
            dir_up_q <= 1'b1;
            step_q   <= 1'b0;
        end else begin
            led_q    <= led_d;
            mode_q   <= mode_d;
            dir_up_q <= dir_up_d;
            step_q   <= step_d;
        end
    end

    assign o_led  = led_q;
    assign o_step = step_q;

endmodule

// File: tb/tb_vfd_led_sequencer.sv
// Directed bench for vfd_led_sequencer (N_LEDS=8).
// Inputs change on the falling edge, and outputs are checked there as well.
module tb_vfd_led_sequencer;

    logic       clk;
    logic       rst;
    logic       i_tick;
    logic       i_run;
    logic [1:0] i_mode;
    logic [7:0] o_led;
    logic       o_step;

    int errors = 0;
    int checks = 0;
    int step_cnt = 0;
    int step_base;
    logic [7:0] bnc_exp [16];
    logic [7:0] rol_exp;

    vfd_led_sequencer #(.N_LEDS(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_tick (i_tick),
        .i_run  (i_run),
        .i_mode (i_mode),
        .o_led  (o_led),
        .o_step (o_step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (o_step === 1'b1) step_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle-high tick; returns on the falling edge after the update edge.
    task automatic tick();
        @(negedge clk);
        i_tick = 1'b1;
        @(negedge clk);
        i_tick = 1'b0;
    endtask

    initial begin
        bnc_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                    8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
        rst = 1'b1; i_tick = 1'b1; i_run = 1'b0; i_mode = 2'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_led", o_led, 8'h00);
        chk("reset_step", o_step, 1'b0);

        // High tick out of reset must not count as an edge
        @(negedge clk);
        chk("no_spurious_step", o_step, 1'b0);
        i_tick = 1'b0;
        tick();
        chk("idle_ignores_led", o_led, 8'h00);
        chk("idle_ignores_step", o_step, 1'b0);

        // Rotate-left
        step_base = step_cnt;
        i_run = 1'b1;
        @(negedge clk);
        chk("rol_seed_led", o_led, 8'h01);
        chk("rol_seed_step", o_step, 1'b1);
        rol_exp = 8'h01;
        for (int i = 0; i < 8; i++) begin
            tick();
            rol_exp = {rol_exp[6:0], rol_exp[7]};
            chk("rol_led", o_led, rol_exp);
            chk("rol_step", o_step, 1'b1);
        end
        @(negedge clk);
        chk("rol_step_low", o_step, 1'b0);
        chk("rol_step_count", step_cnt - step_base, 9);

        // Bounce: first edge after the mode change reseeds
        i_mode = 2'd2;
        tick();
        chk("bnc_seed", o_led, 8'h01);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("bnc_led", o_led, bnc_exp[i]);
        end

        // Count: reseed to zero, run up to 0xFE, then wrap
        i_mode = 2'd3;
        tick();
        chk("cnt_seed", o_led, 8'h00);
        chk("cnt_seed_step", o_step, 1'b1);
        repeat (254) tick();
        chk("cnt_fe", o_led, 8'hFE);
        tick();
        chk("cnt_ff", o_led, 8'hFF);
        tick();
        chk("cnt_wrap", o_led, 8'h00);
        tick();
        chk("cnt_01", o_led, 8'h01);

        // Edge coincident with i_run falling is dropped
        @(negedge clk);
        i_tick = 1'b1;
        i_run  = 1'b0;
        @(negedge clk);
        i_tick = 1'b0;
        chk("pause_edge_led", o_led, 8'h01);
        chk("pause_edge_step", o_step, 1'b0);
        step_base = step_cnt;
        repeat (5) tick();
        chk("pause_hold_led", o_led, 8'h01);
        chk("pause_no_steps", step_cnt - step_base, 0);
        i_mode = 2'd1;
        @(negedge clk);
        i_run = 1'b1;
        @(negedge clk);
        chk("resume_no_reload", o_led, 8'h01);
        chk("resume_no_step", o_step, 1'b0);
        tick();
        chk("ror_seed", o_led, 8'h80);
        tick();
        chk("ror_next", o_led, 8'h40);
        tick();
        chk("ror_next2", o_led, 8'h20);

        // Async reset mid-bounce, while o_step is high
        i_mode = 2'd2;
        tick();
        chk("bnc2_seed", o_led, 8'h01);
        tick();
        tick();
        chk("bnc2_led", o_led, 8'h04);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_led", o_led, 8'h00);
        chk("async_rst_step", o_step, 1'b0);
        i_run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_idle_led", o_led, 8'h00);
        chk("post_rst_idle_step", o_step, 1'b0);

        // Edge in the idle->run cycle gives only the seed load
        @(negedge clk);
        i_tick = 1'b1;
        i_run  = 1'b1;
        @(negedge clk);
        i_tick = 1'b0;
        chk("idle_run_edge_led", o_led, 8'h01);
        chk("idle_run_edge_step", o_step, 1'b1);
        @(negedge clk);
        chk("idle_run_step_once", o_step, 1'b0);
        chk("idle_run_hold", o_led, 8'h01);
        tick();
        chk("bnc3_next", o_led, 8'h02);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
